// File: rtl/rr_sel_pkg.sv
// ============================================================================
// Module   : rr_sel_pkg
// Purpose  : Shared types and constants for the round-robin select arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_sel_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        GRANT  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Rotating-priority search: first set req bit at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import rr_sel_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_sel_arbiter.sv
// ============================================================================
// Module   : rr_sel_arbiter
// Purpose  : 4-source round-robin arbiter driving a registered 4:1 mux select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_sel_arbiter
    import rr_sel_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             release_in,  // "release" is a reserved word
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             valid,
    output logic             preempt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e           state_q,   state_d;
    logic [SEL_W-1:0] ptr_q,     ptr_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic [NREQ-1:0]  gnt_q,     gnt_d;
    logic             valid_q,   valid_d;
    logic             preempt_q, preempt_d;
    logic [7:0]       hold_q,    hold_d;

    logic             idle_found;
    logic [SEL_W-1:0] idle_idx;
    logic             next_found;
    logic [SEL_W-1:0] next_idx;
    logic [SEL_W-1:0] next_ptr;
    logic [NREQ-1:0]  owner_mask;
    logic             others;
    logic             forced;

    assign next_ptr   = sel_q + SEL_W'(1);
    assign owner_mask = NREQ'(1) << sel_q;

    rr_pick u_pick_idle (
        .req   (req),
        .ptr   (ptr_q),
        .found (idle_found),
        .idx   (idle_idx)
    );

    // Search from the pointer the owner will leave behind, so a grant exit
    // can chain straight into the next SWITCH.
    rr_pick u_pick_next (
        .req   (req),
        .ptr   (next_ptr),
        .found (next_found),
        .idx   (next_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = '0;
        valid_d   = 1'b0;
        preempt_d = 1'b0;
        hold_d    = '0;
        others    = |(req & ~owner_mask);
        forced    = (hold_q == HOLD_LAST) && others;

        case (state_q)
            IDLE: begin
                if (en && idle_found) begin
                    sel_d   = idle_idx;
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                state_d = GRANT;
                gnt_d   = owner_mask;
                valid_d = 1'b1;
            end
            GRANT: begin
                if (release_in || !req[sel_q] || forced) begin
                    preempt_d = !release_in && req[sel_q];
                    ptr_d     = next_ptr;
                    if (en && next_found) begin
                        sel_d   = next_idx;
                        state_d = SWITCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gnt_d   = owner_mask;
                    valid_d = 1'b1;
                    hold_d  = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_sel_arbiter.sv
// ============================================================================
// Module   : tb_rr_sel_arbiter
// Purpose  : Self-checking bench for rr_sel_arbiter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_sel_arbiter;

    localparam int TB_MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       release_in = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;

    rr_sel_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .release_in (release_in),
        .en         (en),
        .sel        (sel),
        .gnt        (gnt),
        .valid      (valid),
        .preempt    (preempt)
    );

    always #5 clk = ~clk;

    // Behavioural reference: phase 0 = idle, 1 = switching, 2 = granted.
    int m_phase, m_ptr, m_sel, m_hold;
    bit m_pre;

    function automatic int first_req(int p, logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ptr <= 0; m_sel <= 0; m_hold <= 0; m_pre <= 0;
        end else begin
            automatic int ph = m_phase, pt = m_ptr, s = m_sel, h = m_hold, f;
            automatic bit pr = 0, others, frc;
            if (m_phase == 0) begin
                f = first_req(m_ptr, req);
                if (en && f >= 0) begin s = f; ph = 1; end
            end else if (m_phase == 1) begin
                ph = 2; h = 0;
            end else begin
                others = (req & ~(4'b0001 << m_sel)) != 4'b0000;
                frc    = (m_hold == TB_MAX_HOLD - 1) && others;
                if (release_in || !req[m_sel] || frc) begin
                    pr = !release_in && req[m_sel];
                    pt = (m_sel + 1) % 4;
                    f  = first_req(pt, req);
                    if (en && f >= 0) begin s = f; ph = 1; end
                    else ph = 0;
                end else if (m_hold < TB_MAX_HOLD - 1) begin
                    h = m_hold + 1;
                end
            end
            m_phase <= ph; m_ptr <= pt; m_sel <= s; m_hold <= h; m_pre <= pr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000; en = 1'b0; release_in = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({sel, gnt, valid, preempt} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel=%0d gnt=%b valid=%b preempt=%b, expected all 0",
                     sel, gnt, valid, preempt);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0101; en = 1'b1;
        step();
        n_checks++;
        if ({sel, valid, gnt} !== {2'd0, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL basic_switch: sel=%0d valid=%b gnt=%b, expected sel=0 valid=0 gnt=0000", sel, valid, gnt);
        end
        step();
        n_checks++;
        if ({sel, valid, gnt} !== {2'd0, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL basic_grant: sel=%0d valid=%b gnt=%b, expected sel=0 valid=1 gnt=0001", sel, valid, gnt);
        end
        release_in = 1'b1;
        step();
        release_in = 1'b0;
        n_checks++;
        if ({sel, valid, gnt} !== {2'd2, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL basic_release_switch: sel=%0d valid=%b gnt=%b, expected sel=2 valid=0 gnt=0000", sel, valid, gnt);
        end
        step();
        n_checks++;
        if ({sel, valid, gnt} !== {2'd2, 1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL basic_regrant: sel=%0d valid=%b gnt=%b, expected sel=2 valid=1 gnt=0100", sel, valid, gnt);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        req = 4'b0011; en = 1'b1;
        step();
        for (int c = 0; c < TB_MAX_HOLD; c++) begin
            step();
            n_checks++;
            if ({gnt, preempt} !== {4'b0001, 1'b0}) begin
                n_fail++;
                $display("FAIL preempt_hold cycle %0d: gnt=%b preempt=%b, expected gnt=0001 preempt=0", c, gnt, preempt);
            end
        end
        step();
        n_checks++;
        if ({gnt, valid, preempt, sel} !== {4'b0000, 1'b0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL preempt_pulse: gnt=%b valid=%b preempt=%b sel=%0d, expected 0000 0 1 1", gnt, valid, preempt, sel);
        end
        step();
        n_checks++;
        if ({gnt, valid, preempt} !== {4'b0010, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL preempt_next: gnt=%b valid=%b preempt=%b, expected 0010 1 0", gnt, valid, preempt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000; en = 1'b1;
        step(); step();
        n_checks++;
        if ({sel, gnt} !== {2'd3, 4'b1000}) begin
            n_fail++;
            $display("FAIL wrap_owner: sel=%0d gnt=%b, expected sel=3 gnt=1000", sel, gnt);
        end
        req = 4'b1001; release_in = 1'b1;
        step();
        release_in = 1'b0;
        n_checks++;
        if ({sel, dut.ptr_q} !== {2'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL wrap_ptr: sel=%0d ptr=%0d, expected sel=0 ptr=0", sel, dut.ptr_q);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant: gnt=%b, expected 0001", gnt);
        end
    endtask

    task automatic test_sole();
        do_reset();
        req = 4'b0100; en = 1'b1;
        step(); step();
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if ({gnt, valid, preempt} !== {4'b0100, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL sole_hold cycle %0d: gnt=%b valid=%b preempt=%b, expected 0100 1 0", c, gnt, valid, preempt);
            end
            step();
        end
    endtask

    task automatic test_en_off();
        do_reset();
        req = 4'b0010; en = 1'b1;
        step(); step();
        req = 4'b0011; en = 1'b0;
        step(); step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL en_off_continue: gnt=%b, expected 0010", gnt);
        end
        release_in = 1'b1;
        step();
        release_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({valid, gnt, sel} !== {1'b0, 4'b0000, 2'd1}) begin
                n_fail++;
                $display("FAIL en_off_idle cycle %0d: valid=%b gnt=%b sel=%0d, expected 0 0000 1", c, valid, gnt, sel);
            end
            step();
        end
        en = 1'b1;
        step(); step();
        n_checks++;
        if ({sel, gnt, valid} !== {2'd0, 4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL en_on_grant: sel=%0d gnt=%b valid=%b, expected 0 0001 1", sel, gnt, valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000; en = 1'b1;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, valid, sel} !== {4'b0000, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b valid=%b sel=%0d, expected 0000 0 0", gnt, valid, sel);
        end
        step();
        rst_n = 1'b1;
        step(); step();
        n_checks++;
        if ({sel, gnt, valid} !== {2'd3, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_grant: sel=%0d gnt=%b valid=%b, expected 3 1000 1", sel, gnt, valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req        = 4'($urandom_range(0, 15));
            release_in = ($urandom_range(0, 3) == 0);
            en         = ($urandom_range(0, 7) != 0);
            step();
            eg = (m_phase == 2) ? (4'b0001 << m_sel) : 4'b0000;
            n_checks++;
            if ({sel, gnt, valid, preempt} !== {2'(m_sel), eg, m_phase == 2, m_pre}) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: sel=%0d gnt=%b valid=%b preempt=%b, expected %0d %b %b %b",
                         c, sel, gnt, valid, preempt, m_sel, eg, m_phase == 2, m_pre);
            end
            n_checks++;
            if (!$onehot0(gnt) || (valid !== (gnt != 4'b0000))) begin
                n_fail++;
                $display("FAIL random_onehot cycle %0d: gnt=%b valid=%b, expected one-hot/zero gnt with valid=|gnt", c, gnt, valid);
            end
        end
        req = 4'b0000; en = 1'b0; release_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_preempt();
        test_wrap();
        test_sole();
        test_en_off();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
